// File: rtl/decode_stage.sv
// RV32I (+optional M, Zicsr) decode stage with an ID/EX output register,
// valid/ready flow control, load-use interlock and branch flush.
module decode_stage #(
    parameter int unsigned LOAD_LATENCY      = 1,
    parameter bit          SUPPORT_M         = 1'b0,
    parameter bit          SUPPORT_CSR_WRITE = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instruction,
    output logic [4:0]  o_rs1_id,
    output logic [4:0]  o_rs2_id,
    input  logic [31:0] i_rs1_data,
    input  logic [31:0] i_rs2_data,
    output logic [11:0] o_csr_id,
    input  logic [31:0] i_csr_data,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [3:0]  o_alu_opcode,
    output logic [31:0] o_alu_op1,
    output logic [31:0] o_alu_op2,
    output logic [4:0]  o_rd_id,
    output logic        o_is_reg_write,
    output logic        o_is_load,
    output logic        o_is_store,
    output logic [2:0]  o_load_store_type,
    output logic        o_is_jump,
    output logic [31:0] o_jump_address,
    output logic        o_is_branch,
    output logic [2:0]  o_branch_type,
    output logic [31:0] o_store_data,
    output logic        o_is_muldiv,
    output logic [2:0]  o_muldiv_op,
    output logic        o_csr_we,
    output logic [31:0] o_csr_wdata,
    output logic [11:0] o_csr_waddr,
    output logic        o_illegal,
    output logic [31:0] o_pc
);
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4,
        ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9
    } alu_opcode_t;

    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                           OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

    function automatic alu_opcode_t alu_fn(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = i_instruction[6:0];
    assign rd     = i_instruction[11:7];
    assign f3     = i_instruction[14:12];
    assign rs1    = i_instruction[19:15];
    assign rs2    = i_instruction[24:20];
    assign f7     = i_instruction[31:25];
    assign imm_i  = {{20{i_instruction[31]}}, i_instruction[31:20]};
    assign imm_s  = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
    assign imm_b  = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                     i_instruction[30:25], i_instruction[11:8], 1'b0};
    assign imm_u  = {i_instruction[31:12], 12'd0};
    assign imm_j  = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                     i_instruction[20], i_instruction[30:21], 1'b0};

    assign o_rs1_id = rs1;
    assign o_rs2_id = rs2;
    assign o_csr_id = i_instruction[31:20];

    // Stage p0: combinational decode of the incoming instruction
    alu_opcode_t alu_op_p0;
    logic [31:0] op1_p0, op2_p0, jump_addr_p0, store_data_p0, csr_src_p0, csr_wdata_p0;
    logic        reg_write_p0, load_p0, store_p0, jump_p0, branch_p0, muldiv_p0, csr_we_p0;
    logic        illegal_p0, uses_rs1_p0, uses_rs2_p0;
    logic [2:0]  ls_type_p0, br_type_p0, muldiv_op_p0;

    always_comb begin
        alu_op_p0     = ALU_ADD;
        op1_p0        = '0;
        op2_p0        = '0;
        jump_addr_p0  = '0;
        store_data_p0 = '0;
        csr_src_p0    = f3[2] ? {27'd0, rs1} : i_rs1_data;
        csr_wdata_p0  = '0;
        reg_write_p0  = 1'b0;
        load_p0       = 1'b0;
        store_p0      = 1'b0;
        jump_p0       = 1'b0;
        branch_p0     = 1'b0;
        muldiv_p0     = 1'b0;
        csr_we_p0     = 1'b0;
        illegal_p0    = 1'b0;
        ls_type_p0    = '0;
        br_type_p0    = '0;
        muldiv_op_p0  = '0;
        case (opcode)
            OP_LUI:   begin op2_p0 = imm_u; reg_write_p0 = 1'b1; end
            OP_AUIPC: begin op1_p0 = i_pc; op2_p0 = imm_u; reg_write_p0 = 1'b1; end
            OP_JAL: begin
                op1_p0 = i_pc; op2_p0 = 32'd4; reg_write_p0 = 1'b1;
                jump_p0 = 1'b1; jump_addr_p0 = i_pc + imm_j;
            end
            OP_JALR: begin
                op1_p0 = i_pc; op2_p0 = 32'd4; reg_write_p0 = 1'b1;
                jump_p0 = 1'b1; jump_addr_p0 = (i_rs1_data + imm_i) & 32'hFFFF_FFFE;
            end
            OP_BRANCH: begin
                op1_p0 = i_rs1_data; op2_p0 = i_rs2_data; alu_op_p0 = ALU_SUB;
                branch_p0 = 1'b1; br_type_p0 = f3; jump_addr_p0 = i_pc + imm_b;
            end
            OP_LOAD: begin
                op1_p0 = i_rs1_data; op2_p0 = imm_i; load_p0 = 1'b1;
                reg_write_p0 = 1'b1; ls_type_p0 = f3;
            end
            OP_STORE: begin
                op1_p0 = i_rs1_data; op2_p0 = imm_s; store_p0 = 1'b1;
                ls_type_p0 = f3; store_data_p0 = i_rs2_data;
            end
            OP_IMM: begin
                op1_p0 = i_rs1_data; op2_p0 = imm_i; reg_write_p0 = 1'b1;
                alu_op_p0 = alu_fn(f3, (f3 == 3'b101) && f7[5]);
            end
            OP_REG: begin
                op1_p0 = i_rs1_data; op2_p0 = i_rs2_data; reg_write_p0 = 1'b1;
                if (f7 == 7'b0000000)                   alu_op_p0 = alu_fn(f3, 1'b0);
                else if (f7 == 7'b0100000)              alu_op_p0 = alu_fn(f3, 1'b1);
                else if (f7 == 7'b0000001 && SUPPORT_M) begin muldiv_p0 = 1'b1; muldiv_op_p0 = f3; end
                else                                    illegal_p0 = 1'b1;
            end
            OP_FENCE: ;
            OP_SYSTEM: begin
                // Without CSR write support only a pure read (CSRRS rs1=x0) survives
                if (f3[1:0] != 2'b00 && (SUPPORT_CSR_WRITE || (f3 == 3'b010 && rs1 == 5'd0))) begin
                    op1_p0 = i_csr_data; reg_write_p0 = 1'b1;
                    case (f3[1:0])
                        2'b01:   csr_wdata_p0 = csr_src_p0;
                        2'b10:   csr_wdata_p0 = i_csr_data | csr_src_p0;
                        default: csr_wdata_p0 = i_csr_data & ~csr_src_p0;
                    endcase
                    csr_we_p0 = (f3[1:0] == 2'b01) || (rs1 != 5'd0);
                end else begin
                    illegal_p0 = 1'b1;
                end
            end
            default: illegal_p0 = 1'b1;
        endcase
        if (illegal_p0) begin
            reg_write_p0 = 1'b0; load_p0 = 1'b0; store_p0 = 1'b0; jump_p0 = 1'b0;
            branch_p0 = 1'b0; csr_we_p0 = 1'b0; muldiv_p0 = 1'b0;
        end
    end

    assign uses_rs1_p0 = !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL ||
                           (opcode == OP_SYSTEM && f3[2]));
    assign uses_rs2_p0 = (opcode == OP_REG) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

    logic [4:0] pend_rd;
    logic [2:0] pend_cnt;
    logic       held_load, pend_active, hazard, load_en;

    assign held_load   = o_valid && o_is_load && (o_rd_id != 5'd0);
    assign pend_active = held_load || (pend_cnt != 3'd0);
    assign hazard      = pend_active && ((uses_rs1_p0 && rs1 == pend_rd) ||
                                         (uses_rs2_p0 && rs2 == pend_rd));
    assign o_ready     = i_flush || ((!o_valid || i_ready) && !hazard);
    assign load_en     = i_valid && o_ready && !i_flush && !hazard;

    // Stage p1: ID/EX output register and load-use scoreboard
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0; pend_rd <= '0; pend_cnt <= '0;
            o_alu_opcode <= '0; o_alu_op1 <= '0; o_alu_op2 <= '0; o_rd_id <= '0;
            o_is_reg_write <= 1'b0; o_is_load <= 1'b0; o_is_store <= 1'b0;
            o_load_store_type <= '0; o_is_jump <= 1'b0; o_jump_address <= '0;
            o_is_branch <= 1'b0; o_branch_type <= '0; o_store_data <= '0;
            o_is_muldiv <= 1'b0; o_muldiv_op <= '0; o_csr_we <= 1'b0;
            o_csr_wdata <= '0; o_csr_waddr <= '0; o_illegal <= 1'b0; o_pc <= '0;
        end else begin
            if (i_flush)                o_valid <= 1'b0;
            else if (load_en)           o_valid <= 1'b1;
            else if (!o_valid || i_ready) o_valid <= 1'b0;

            if (load_en) begin
                o_alu_opcode <= alu_op_p0; o_alu_op1 <= op1_p0; o_alu_op2 <= op2_p0;
                o_rd_id <= rd; o_is_reg_write <= reg_write_p0; o_is_load <= load_p0;
                o_is_store <= store_p0; o_load_store_type <= ls_type_p0;
                o_is_jump <= jump_p0; o_jump_address <= jump_addr_p0;
                o_is_branch <= branch_p0; o_branch_type <= br_type_p0;
                o_store_data <= store_data_p0; o_is_muldiv <= muldiv_p0;
                o_muldiv_op <= muldiv_op_p0; o_csr_we <= csr_we_p0;
                o_csr_wdata <= csr_wdata_p0; o_csr_waddr <= i_instruction[31:20];
                o_illegal <= illegal_p0; o_pc <= i_pc;
            end

            // The hand-off cycle is itself the first latency cycle, hence L-1 remaining
            if (load_en && load_p0 && rd != 5'd0) begin
                pend_rd  <= rd;
                pend_cnt <= '0;
            end else if (!i_flush && i_ready && held_load) begin
                pend_cnt <= 3'(LOAD_LATENCY - 1);
            end else if (pend_cnt != 3'd0) begin
                pend_cnt <= pend_cnt - 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: scoreboard of expected ID/EX contents plus
// cycle-level checks of ready/valid around stalls, backpressure and flush.
module tb_decode_stage;
    logic        i_clk, i_rst_n, i_valid, i_flush, i_ready;
    logic [31:0] i_pc, i_instruction, i_rs1_data, i_rs2_data, i_csr_data;

    logic        o_ready, o_valid, o_is_reg_write, o_is_load, o_is_store, o_is_jump;
    logic        o_is_branch, o_is_muldiv, o_csr_we, o_illegal;
    logic [4:0]  o_rs1_id, o_rs2_id, o_rd_id;
    logic [11:0] o_csr_id, o_csr_waddr;
    logic [3:0]  o_alu_opcode;
    logic [31:0] o_alu_op1, o_alu_op2, o_jump_address, o_store_data, o_csr_wdata, o_pc;
    logic [2:0]  o_load_store_type, o_branch_type, o_muldiv_op;

    logic        m_ready, m_valid, m_is_reg_write, m_is_load, m_is_store, m_is_jump;
    logic        m_is_branch, m_is_muldiv, m_csr_we, m_illegal;
    logic [4:0]  m_rs1_id, m_rs2_id, m_rd_id;
    logic [11:0] m_csr_id, m_csr_waddr;
    logic [3:0]  m_alu_opcode;
    logic [31:0] m_alu_op1, m_alu_op2, m_jump_address, m_store_data, m_csr_wdata, m_pc;
    logic [2:0]  m_load_store_type, m_branch_type, m_muldiv_op;

    decode_stage #(.LOAD_LATENCY(1), .SUPPORT_M(1'b0), .SUPPORT_CSR_WRITE(1'b1)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_instruction(i_instruction), .o_rs1_id(o_rs1_id), .o_rs2_id(o_rs2_id),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .o_csr_id(o_csr_id),
        .i_csr_data(i_csr_data), .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_alu_opcode(o_alu_opcode), .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2),
        .o_rd_id(o_rd_id), .o_is_reg_write(o_is_reg_write), .o_is_load(o_is_load),
        .o_is_store(o_is_store), .o_load_store_type(o_load_store_type), .o_is_jump(o_is_jump),
        .o_jump_address(o_jump_address), .o_is_branch(o_is_branch),
        .o_branch_type(o_branch_type), .o_store_data(o_store_data), .o_is_muldiv(o_is_muldiv),
        .o_muldiv_op(o_muldiv_op), .o_csr_we(o_csr_we), .o_csr_wdata(o_csr_wdata),
        .o_csr_waddr(o_csr_waddr), .o_illegal(o_illegal), .o_pc(o_pc)
    );

    decode_stage #(.LOAD_LATENCY(1), .SUPPORT_M(1'b1), .SUPPORT_CSR_WRITE(1'b1)) dut_m (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(m_ready),
        .i_pc(i_pc), .i_instruction(i_instruction), .o_rs1_id(m_rs1_id), .o_rs2_id(m_rs2_id),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .o_csr_id(m_csr_id),
        .i_csr_data(i_csr_data), .i_flush(i_flush), .o_valid(m_valid), .i_ready(i_ready),
        .o_alu_opcode(m_alu_opcode), .o_alu_op1(m_alu_op1), .o_alu_op2(m_alu_op2),
        .o_rd_id(m_rd_id), .o_is_reg_write(m_is_reg_write), .o_is_load(m_is_load),
        .o_is_store(m_is_store), .o_load_store_type(m_load_store_type), .o_is_jump(m_is_jump),
        .o_jump_address(m_jump_address), .o_is_branch(m_is_branch),
        .o_branch_type(m_branch_type), .o_store_data(m_store_data), .o_is_muldiv(m_is_muldiv),
        .o_muldiv_op(m_muldiv_op), .o_csr_we(m_csr_we), .o_csr_wdata(m_csr_wdata),
        .o_csr_waddr(m_csr_waddr), .o_illegal(m_illegal), .o_pc(m_pc)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [3:0]  alu;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        st;
        logic        ill;
        logic        csr_we;
        logic [31:0] csr_wdata;
        logic        chk_ops;
        logic        chk_m;
    } exp_t;

    exp_t sb[$];
    exp_t cur_exp;
    exp_t e;
    int   n_assert = 0;
    int   n_fail   = 0;
    logic rdy_s, vld_s;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t e_alu(input logic [31:0] pc, input logic [3:0] alu,
                                   input logic [31:0] op1, input logic [31:0] op2,
                                   input logic [4:0] rd);
        exp_t r;
        r = '0;
        r.pc = pc; r.alu = alu; r.op1 = op1; r.op2 = op2; r.rd = rd;
        r.rw = 1'b1; r.chk_ops = 1'b1;
        return r;
    endfunction

    function automatic exp_t e_ill(input logic [31:0] pc);
        exp_t r;
        r = '0;
        r.pc = pc; r.ill = 1'b1;
        return r;
    endfunction

    task automatic pop_check();
        exp_t x;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
            return;
        end
        x = sb.pop_front();
        check("pc", o_pc, x.pc);
        check("illegal", 32'(o_illegal), 32'(x.ill));
        check("reg_write", 32'(o_is_reg_write), 32'(x.rw));
        check("is_load", 32'(o_is_load), 32'(x.ld));
        check("is_store", 32'(o_is_store), 32'(x.st));
        check("csr_we", 32'(o_csr_we), 32'(x.csr_we));
        check("is_muldiv", 32'(o_is_muldiv), 32'd0);
        if (x.chk_ops) begin
            check("alu_opcode", 32'(o_alu_opcode), 32'(x.alu));
            check("alu_op1", o_alu_op1, x.op1);
            check("alu_op2", o_alu_op2, x.op2);
            check("rd_id", 32'(o_rd_id), 32'(x.rd));
            check("csr_wdata", o_csr_wdata, x.csr_wdata);
        end
        if (x.chk_m) begin
            check("m_is_muldiv", 32'(m_is_muldiv), 32'd1);
            check("m_muldiv_op", 32'(m_muldiv_op), 32'd0);
            check("m_illegal", 32'(m_illegal), 32'd0);
            check("m_reg_write", 32'(m_is_reg_write), 32'd1);
        end
    endtask

    task automatic tick();
        @(negedge i_clk);
        rdy_s = o_ready;
        vld_s = o_valid;
        if (o_valid && i_ready && !i_flush) pop_check();
        if (i_flush)                  sb.delete();
        else if (i_valid && o_ready)  sb.push_back(cur_exp);
        @(posedge i_clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] csr, input exp_t x);
        i_valid = 1'b1; i_instruction = instr; i_pc = pc;
        i_rs1_data = r1; i_rs2_data = r2; i_csr_data = csr; cur_exp = x;
    endtask

    task automatic idle();
        i_valid = 1'b0; i_instruction = '0; i_pc = '0;
        i_rs1_data = '0; i_rs2_data = '0; i_csr_data = '0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_flush = 1'b0; i_ready = 1'b1; cur_exp = '0;
        idle();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_alu_opcode", 32'(o_alu_opcode), 32'd0);
        check("rst_op1", o_alu_op1, 32'd0);
        check("rst_rd", 32'(o_rd_id), 32'd0);
        check("rst_reg_write", 32'(o_is_reg_write), 32'd0);
        check("rst_pc", o_pc, 32'd0);
        i_rst_n = 1'b1;
        tick();
        check("ready_after_reset", 32'(rdy_s), 32'd1);

        // back-to-back: addi x1,x0,5 ; add x2,x1,x1 ; sub x6,x1,x2
        drive(32'h00500093, 32'h100, 32'd0, 32'd0, 32'd0, e_alu(32'h100, 4'd0, 32'd0, 32'd5, 5'd1));
        tick();
        drive(32'h00108133, 32'h104, 32'd5, 32'd5, 32'd0, e_alu(32'h104, 4'd0, 32'd5, 32'd5, 5'd2));
        tick();
        check("b2b_ready", 32'(rdy_s), 32'd1);
        check("b2b_valid0", 32'(vld_s), 32'd1);
        drive(32'h40208333, 32'h108, 32'd5, 32'd7, 32'd0, e_alu(32'h108, 4'd1, 32'd5, 32'd7, 5'd6));
        tick();
        check("b2b_valid1", 32'(vld_s), 32'd1);
        idle();
        tick();
        check("b2b_valid2", 32'(vld_s), 32'd1);

        // load-use: lw x3,0(x1) ; add x4,x3,x0
        e = e_alu(32'h120, 4'd0, 32'h1000, 32'd0, 5'd3); e.ld = 1'b1;
        drive(32'h0000A183, 32'h120, 32'h1000, 32'd0, 32'd0, e);
        tick();
        drive(32'h00018233, 32'h124, 32'h77, 32'd0, 32'd0, e_alu(32'h124, 4'd0, 32'h77, 32'd0, 5'd4));
        tick();
        check("lu_stall", 32'(rdy_s), 32'd0);
        check("lu_load_out", 32'(vld_s), 32'd1);
        tick();
        check("lu_resume", 32'(rdy_s), 32'd1);
        check("lu_bubble", 32'(vld_s), 32'd0);
        idle();
        tick();
        check("lu_dep_out", 32'(vld_s), 32'd1);

        // load to x0 never interlocks
        e = e_alu(32'h130, 4'd0, 32'h1000, 32'd0, 5'd0); e.ld = 1'b1;
        drive(32'h0000A003, 32'h130, 32'h1000, 32'd0, 32'd0, e);
        tick();
        drive(32'h00000233, 32'h134, 32'd0, 32'd0, 32'd0, e_alu(32'h134, 4'd0, 32'd0, 32'd0, 5'd4));
        tick();
        check("x0_no_stall", 32'(rdy_s), 32'd1);
        idle();
        tick();
        check("x0_dep_out", 32'(vld_s), 32'd1);

        // backpressure: hold i_ready low for three cycles
        drive(32'h00500093, 32'h200, 32'd0, 32'd0, 32'd0, e_alu(32'h200, 4'd0, 32'd0, 32'd5, 5'd1));
        tick();
        i_ready = 1'b0;
        drive(32'h00108133, 32'h204, 32'd9, 32'd9, 32'd0, e_alu(32'h204, 4'd0, 32'd9, 32'd9, 5'd2));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_ready_low", 32'(rdy_s), 32'd0);
            check("bp_valid_held", 32'(vld_s), 32'd1);
            check("bp_op2_frozen", o_alu_op2, 32'd5);
            check("bp_pc_frozen", o_pc, 32'h200);
        end
        i_ready = 1'b1;
        tick();
        check("bp_release_ready", 32'(rdy_s), 32'd1);
        idle();
        tick();
        check("bp_next_out", 32'(vld_s), 32'd1);

        // flush with a held load and a dependent incoming instruction
        i_ready = 1'b0;
        e = e_alu(32'h300, 4'd0, 32'h1000, 32'd0, 5'd3); e.ld = 1'b1;
        drive(32'h0000A183, 32'h300, 32'h1000, 32'd0, 32'd0, e);
        tick();
        i_flush = 1'b1;
        drive(32'h00018233, 32'h304, 32'h77, 32'd0, 32'd0, e_alu(32'h304, 4'd0, 32'h77, 32'd0, 5'd4));
        tick();
        check("flush_ready", 32'(rdy_s), 32'd1);
        i_flush = 1'b0;
        i_ready = 1'b1;
        tick();
        check("flush_kills", 32'(vld_s), 32'd0);
        check("flush_no_hazard", 32'(rdy_s), 32'd1);
        idle();
        tick();
        check("flush_next_out", 32'(vld_s), 32'd1);

        // csrrc x5,0x300,x6 then csrrs x5,0x300,x0
        e = e_alu(32'h400, 4'd0, 32'hF0F0, 32'd0, 5'd5); e.csr_we = 1'b1; e.csr_wdata = 32'hF000;
        drive(32'h300332F3, 32'h400, 32'h00F0, 32'hDEAD, 32'hF0F0, e);
        #1;
        check("rs1_id", 32'(o_rs1_id), 32'd6);
        check("csr_id", 32'(o_csr_id), 32'h300);
        tick();
        e = e_alu(32'h404, 4'd0, 32'h1234, 32'd0, 5'd5); e.csr_wdata = 32'h1234;
        drive(32'h300022F3, 32'h404, 32'd0, 32'd0, 32'h1234, e);
        tick();
        idle();
        tick();
        check("csr_waddr", 32'(o_csr_waddr), 32'h300);

        // illegal opcode, then mul (illegal here, decoded by the M-capable instance)
        drive(32'h0000007F, 32'h500, 32'd1, 32'd2, 32'd0, e_ill(32'h500));
        tick();
        e = e_ill(32'h504); e.chk_m = 1'b1;
        drive(32'h022083B3, 32'h504, 32'd3, 32'd4, 32'd0, e);
        tick();
        idle();
        tick();
        tick();
        check("final_idle", 32'(vld_s), 32'd0);

        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
